// File: rtl/i2c_uart_tx_arbiter.sv
// i2c_uart_tx_arbiter: shares one UART transmitter between a FIFO of bytes
// received over I2C and a single-entry status request channel. Round-robin
// arbitration, tx_start/tx_busy handshake sequencing, start timeout and
// FIFO overflow detection.
// Optional build macro: I2CU_FRAME_EN adds a FRAME requester that sends
// FRAME_BYTE after each I2C transaction that delivered at least one byte.
module i2c_uart_tx_arbiter #(
    parameter int          DEPTH      = 8,
    parameter int          BUSY_TO    = 15,
    parameter logic [7:0]  FRAME_BYTE = 8'h0A
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               i2c_data,
    input  logic                     i2c_valid,
    input  logic                     i2c_stop,
    input  logic                     stat_req,
    input  logic [7:0]               stat_data,
    output logic                     stat_ack,
    output logic [7:0]               tx_data,
    output logic                     tx_start,
    input  logic                     tx_busy,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow,
    output logic                     start_err,
    input  logic                     err_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(BUSY_TO + 1);
    localparam logic GRANT_DATA = 1'b0;
    localparam logic GRANT_STAT = 1'b1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t          state_r, next_state_s;
    logic [7:0]      mem_r [DEPTH];
    logic [AW-1:0]   wr_ptr_r, rd_ptr_r;
    logic [LW-1:0]   count_r;
    logic [CW-1:0]   cnt_r;
    logic            last_grant_r;
    logic [7:0]      tx_data_r;
    logic            tx_start_r, stat_ack_r, overflow_r, start_err_r;

    logic            full_s, push_s, drop_s, pop_s;
    logic            data_cand_s, frame_cand_s;
    logic            grant_data_s, grant_stat_s, grant_frame_s, grant_any_s;
    logic            cnt_clr_s, cnt_inc_s, timeout_s;

    // Full is judged on the registered occupancy, so a push into a full FIFO
    // is dropped even when a pop happens in the same cycle.
    assign full_s      = (count_r == LW'(DEPTH));
    assign push_s      = i2c_valid & ~full_s;
    assign drop_s      = i2c_valid & full_s;
    assign pop_s       = grant_data_s;
    assign data_cand_s = (count_r != LW'(0));
    assign grant_any_s = grant_data_s | grant_stat_s | grant_frame_s;

`ifdef I2CU_FRAME_EN
    logic frame_pend_r, pushed_since_r, frame_set_s;

    // A stop arms one delimiter, only if bytes arrived since the last one.
    assign frame_set_s  = i2c_stop & ~frame_pend_r & (pushed_since_r | push_s);
    // The delimiter waits for the FIFO to drain so it trails the transaction.
    assign frame_cand_s = frame_pend_r & ~data_cand_s;

    // Pending-delimiter flag and the bytes-since-last-delimiter tracker.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_pend_r   <= 1'b0;
            pushed_since_r <= 1'b0;
        end else begin
            if (frame_set_s) begin
                frame_pend_r <= 1'b1;
            end else if (grant_frame_s) begin
                frame_pend_r <= 1'b0;
            end else begin
                frame_pend_r <= frame_pend_r;
            end
            if (frame_set_s) begin
                pushed_since_r <= 1'b0;
            end else if (push_s) begin
                pushed_since_r <= 1'b1;
            end else begin
                pushed_since_r <= pushed_since_r;
            end
        end
    end
`else
    logic unused_stop_s;
    assign unused_stop_s = i2c_stop;
    assign frame_cand_s  = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state, arbitration and timeout-counter control.
    always_comb begin
        next_state_s  = state_r;
        grant_data_s  = 1'b0;
        grant_stat_s  = 1'b0;
        grant_frame_s = 1'b0;
        cnt_clr_s     = 1'b0;
        cnt_inc_s     = 1'b0;
        timeout_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (data_cand_s && stat_req) begin
                    if (last_grant_r == GRANT_DATA) begin
                        grant_stat_s = 1'b1;
                    end else begin
                        grant_data_s = 1'b1;
                    end
                    next_state_s = LOAD;
                end else if (data_cand_s) begin
                    grant_data_s = 1'b1;
                    next_state_s = LOAD;
                end else if (stat_req) begin
                    grant_stat_s = 1'b1;
                    next_state_s = LOAD;
                end else if (frame_cand_s) begin
                    grant_frame_s = 1'b1;
                    next_state_s  = LOAD;
                end else begin
                    next_state_s = IDLE;
                end
            end
            LOAD: begin
                cnt_clr_s    = 1'b1;
                next_state_s = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                // Busy is still accepted on the BUSY_TO-th cycle after tx_start;
                // the error is declared only once that cycle has passed.
                if (tx_busy) begin
                    next_state_s = WAIT_DONE;
                end else if (cnt_r == CW'(BUSY_TO - 1)) begin
                    timeout_s    = 1'b1;
                    next_state_s = IDLE;
                end else begin
                    cnt_inc_s    = 1'b1;
                    next_state_s = WAIT_BUSY;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = WAIT_DONE;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // FIFO storage; no reset needed, validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= i2c_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + LW'(1);
                2'b01:   count_r <= count_r - LW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Start-timeout counter, cleared while the start pulse is out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (cnt_clr_s) begin
            cnt_r <= '0;
        end else if (cnt_inc_s) begin
            cnt_r <= cnt_r + CW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Grant side effects: byte capture, start pulse, status ack, round-robin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_data_r    <= 8'h00;
            tx_start_r   <= 1'b0;
            stat_ack_r   <= 1'b0;
            last_grant_r <= GRANT_DATA;
        end else begin
            tx_start_r <= grant_any_s;
            stat_ack_r <= grant_stat_s;
            if (grant_data_s) begin
                tx_data_r    <= mem_r[rd_ptr_r];
                last_grant_r <= GRANT_DATA;
            end else if (grant_stat_s) begin
                tx_data_r    <= stat_data;
                last_grant_r <= GRANT_STAT;
            end else if (grant_frame_s) begin
                tx_data_r    <= FRAME_BYTE;
            end
        end
    end

    // Sticky error flags; a set in the current cycle beats a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_r  <= 1'b0;
            start_err_r <= 1'b0;
        end else begin
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (err_clr) begin
                overflow_r <= 1'b0;
            end
            if (timeout_s) begin
                start_err_r <= 1'b1;
            end else if (err_clr) begin
                start_err_r <= 1'b0;
            end
        end
    end

    assign tx_data    = tx_data_r;
    assign tx_start   = tx_start_r;
    assign stat_ack   = stat_ack_r;
    assign fifo_level = count_r;
    assign overflow   = overflow_r;
    assign start_err  = start_err_r;

endmodule
